// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the decode -> scoreboard -> execute path.
// Register indices and the issue-field bundle passed between stages.
package issue_scoreboard_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     writes_rd;
  } issue_fields_t;

endpackage

// File: rtl/issue_scoreboard_hazard_check.sv
// Combinational hazard detection against the registered busy mask.
// No writeback bypass: only the registered busy state is consulted.
module issue_scoreboard_hazard_check
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic [NUM_REGS-1:0] busy_mask,
  input  logic [CW-1:0]       inflight,
  input  issue_fields_t       id_fields,
  input  logic                id_uses_rs2,
  output logic                raw,
  output logic                waw,
  output logic                full
);

  logic w_rd_nz;
  logic w_rs1_busy;
  logic w_rs2_busy;

  always_comb begin
    w_rd_nz    = (id_fields.rd != '0);
    w_rs1_busy = (id_fields.rs1 != '0) && busy_mask[id_fields.rs1];
    w_rs2_busy = id_uses_rs2 && (id_fields.rs2 != '0) && busy_mask[id_fields.rs2];
    raw        = w_rs1_busy || w_rs2_busy;
    waw        = id_fields.writes_rd && w_rd_nz && busy_mask[id_fields.rd];
    full       = id_fields.writes_rd && w_rd_nz && (inflight == CW'(MAX_INFLIGHT));
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard with a one-entry valid/ready issue stage.
// Busy bits are set on issue, cleared on writeback, and wiped by flush.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  output logic                id_ready,
  input  reg_idx_t            id_rd,
  input  reg_idx_t            id_rs1,
  input  reg_idx_t            id_rs2,
  input  logic                id_writes_rd,
  input  logic                id_uses_rs2,
  output logic                iss_valid,
  input  logic                iss_ready,
  output reg_idx_t            iss_rd,
  output reg_idx_t            iss_rs1,
  output reg_idx_t            iss_rs2,
  output logic                iss_writes_rd,
  input  logic                wb_valid,
  input  reg_idx_t            wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CW-1:0]       inflight
);

  logic [NUM_REGS-1:0] r_busy;
  logic [CW-1:0]       r_inflight;
  logic                r_iss_valid;
  issue_fields_t       r_iss;

  issue_fields_t       w_id;
  logic                w_raw;
  logic                w_waw;
  logic                w_full;
  logic                w_fire;
  logic                w_set;
  logic                w_clr;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;

  assign w_id = '{rd: id_rd, rs1: id_rs1, rs2: id_rs2, writes_rd: id_writes_rd};

  issue_scoreboard_hazard_check #(
    .NUM_REGS    (NUM_REGS),
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CW          (CW)
  ) u_hazard (
    .busy_mask  (r_busy),
    .inflight   (r_inflight),
    .id_fields  (w_id),
    .id_uses_rs2(id_uses_rs2),
    .raw        (w_raw),
    .waw        (w_waw),
    .full       (w_full)
  );

  always_comb begin
    id_ready  = !flush && !w_raw && !w_waw && !w_full && (!r_iss_valid || iss_ready);
    w_fire    = id_valid && id_ready;
    w_set     = w_fire && id_writes_rd && (id_rd != '0);
    w_clr     = wb_valid && (wb_rd != '0) && r_busy[wb_rd];
    w_set_vec = '0;
    w_clr_vec = '0;
    w_set_vec[id_rd] = w_set;
    w_clr_vec[wb_rd] = w_clr;
  end

  // Scoreboard state; WAW guarantees set and clear never hit the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_inflight <= '0;
    end else if (flush) begin
      r_busy     <= '0;
      r_inflight <= '0;
    end else begin
      r_busy <= (r_busy | w_set_vec) & ~w_clr_vec & ~NUM_REGS'(1);
      case ({w_set, w_clr})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Output stage: replaced back-to-back when execute drains it in the fire cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iss_valid <= 1'b0;
      r_iss       <= '0;
    end else if (flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_fire) begin
      r_iss_valid     <= 1'b1;
      r_iss.rd        <= id_rd;
      r_iss.rs1       <= id_rs1;
      r_iss.rs2       <= id_rs2;
      r_iss.writes_rd <= id_writes_rd && (id_rd != '0);
    end else if (iss_ready) begin
      r_iss_valid <= 1'b0;
    end
  end

  assign busy_mask     = r_busy;
  assign inflight      = r_inflight;
  assign iss_valid     = r_iss_valid;
  assign iss_rd        = r_iss.rd;
  assign iss_rs1       = r_iss.rs1;
  assign iss_rs2       = r_iss.rs2;
  assign iss_writes_rd = r_iss.writes_rd;

  a_inflight_popcount: assert property (@(posedge clk) disable iff (reset)
    r_inflight == CW'($countones(r_busy)));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int MAX_INFLIGHT = 4;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_ready, id_writes_rd, id_uses_rs2;
  reg_idx_t id_rd, id_rs1, id_rs2;
  logic iss_valid, iss_ready, iss_writes_rd;
  reg_idx_t iss_rd, iss_rs1, iss_rs2;
  logic wb_valid, flush;
  reg_idx_t wb_rd;
  logic [NUM_REGS-1:0] busy_mask;
  logic [CW-1:0] inflight;

  int n_checks = 0;
  int n_errs = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.NUM_REGS(NUM_REGS), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_writes_rd(id_writes_rd), .id_uses_rs2(id_uses_rs2),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_writes_rd(iss_writes_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_mask(busy_mask), .inflight(inflight)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int rd, input int rs1, input int rs2, input logic w, input logic u);
    id_valid = 1'b1;
    id_rd = reg_idx_t'(rd);
    id_rs1 = reg_idx_t'(rs1);
    id_rs2 = reg_idx_t'(rs2);
    id_writes_rd = w;
    id_uses_rs2 = u;
    #1;
  endtask

  task automatic wb(input int rd);
    wb_valid = 1'b1;
    wb_rd = reg_idx_t'(rd);
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0; id_writes_rd = 0; id_uses_rs2 = 0;
    iss_ready = 1'b1; wb_valid = 0; wb_rd = 0; flush = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", 32'(busy_mask), 32'h0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_rd", 32'(iss_rd), 0);
    chk("rst_iss_wr", 32'(iss_writes_rd), 0);
    chk("rst_id_ready", 32'(id_ready), 1);

    // add x3,x1,x2
    present(3, 1, 2, 1, 1);
    chk("add_ready", 32'(id_ready), 1);
    tick();
    id_valid = 0;
    chk("add_iss_valid", 32'(iss_valid), 1);
    chk("add_iss_rd", 32'(iss_rd), 3);
    chk("add_iss_rs1", 32'(iss_rs1), 1);
    chk("add_iss_rs2", 32'(iss_rs2), 2);
    chk("add_iss_wr", 32'(iss_writes_rd), 1);
    chk("add_busy", 32'(busy_mask), 32'h8);
    chk("add_inflight", 32'(inflight), 1);
    tick();
    chk("drain_iss_valid", 32'(iss_valid), 0);

    // RAW stall on x5 and no-bypass writeback timing
    present(5, 0, 0, 1, 0);
    tick();
    chk("x5_busy", 32'(busy_mask), 32'h28);
    present(6, 5, 0, 1, 0);
    chk("raw_stall", 32'(id_ready), 0);
    wb_valid = 1'b1; wb_rd = 5; #1;
    chk("raw_wb_same_cycle", 32'(id_ready), 0);
    tick();
    wb_valid = 1'b0; #1;
    chk("raw_wb_next_cycle", 32'(id_ready), 1);
    chk("raw_wb_busy", 32'(busy_mask), 32'h8);
    chk("raw_wb_inflight", 32'(inflight), 1);
    tick();
    id_valid = 0;
    chk("x6_busy", 32'(busy_mask), 32'h48);
    chk("x6_inflight", 32'(inflight), 2);

    // WAW and x0 destination
    present(6, 0, 0, 1, 0);
    chk("waw_stall", 32'(id_ready), 0);
    present(0, 0, 0, 1, 0);
    chk("x0_ready", 32'(id_ready), 1);
    tick();
    id_valid = 0;
    chk("x0_iss_wr", 32'(iss_writes_rd), 0);
    chk("x0_inflight", 32'(inflight), 2);
    chk("x0_busy", 32'(busy_mask), 32'h48);
    wb(3);
    wb(6);
    chk("empty_busy", 32'(busy_mask), 32'h0);
    chk("empty_inflight", 32'(inflight), 0);

    // Full limit with back-to-back issue
    for (int i = 1; i <= 4; i++) begin
      present(i, 0, 0, 1, 0);
      chk($sformatf("fill_ready_%0d", i), 32'(id_ready), 1);
      tick();
      chk($sformatf("fill_valid_%0d", i), 32'(iss_valid), 1);
    end
    chk("full_inflight", 32'(inflight), 4);
    chk("full_busy", 32'(busy_mask), 32'h1E);
    chk("full_iss_rd", 32'(iss_rd), 4);
    present(6, 0, 0, 1, 0);
    chk("full_stall", 32'(id_ready), 0);
    present(0, 7, 0, 0, 0);
    chk("store_ready", 32'(id_ready), 1);
    tick();
    chk("store_iss_rs1", 32'(iss_rs1), 7);
    chk("store_iss_wr", 32'(iss_writes_rd), 0);
    chk("store_inflight", 32'(inflight), 4);
    present(6, 0, 0, 1, 0);
    chk("full_stall2", 32'(id_ready), 0);
    wb_valid = 1'b1; wb_rd = 2;
    tick();
    wb_valid = 1'b0; #1;
    chk("full_wb_inflight", 32'(inflight), 3);
    chk("full_wb_ready", 32'(id_ready), 1);
    tick();
    chk("x6_issue_rd", 32'(iss_rd), 6);
    chk("x6_issue_inflight", 32'(inflight), 4);
    chk("x6_issue_busy", 32'(busy_mask), 32'h5A);

    // Backpressure: hold stage for 3 cycles
    iss_ready = 1'b0;
    present(0, 11, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_ready_%0d", c), 32'(id_ready), 0);
      chk($sformatf("bp_valid_%0d", c), 32'(iss_valid), 1);
      chk($sformatf("bp_rd_%0d", c), 32'(iss_rd), 6);
      tick();
    end
    iss_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(id_ready), 1);
    tick();
    chk("bp_b2b_valid0", 32'(iss_valid), 1);
    chk("bp_b2b_rs1_0", 32'(iss_rs1), 11);
    present(0, 12, 0, 0, 0);
    tick();
    id_valid = 0;
    chk("bp_b2b_valid1", 32'(iss_valid), 1);
    chk("bp_b2b_rs1_1", 32'(iss_rs1), 12);
    tick();
    chk("bp_drained", 32'(iss_valid), 0);

    // Flush with same-cycle writeback, then late writeback
    wb(1); wb(3); wb(4); wb(6);
    chk("pre_flush_empty", 32'(inflight), 0);
    present(1, 0, 0, 1, 0); tick();
    present(9, 0, 0, 1, 0); tick();
    chk("pre_flush_busy", 32'(busy_mask), 32'h202);
    chk("pre_flush_inflight", 32'(inflight), 2);
    present(0, 0, 0, 0, 0);
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 9; #1;
    chk("flush_ready", 32'(id_ready), 0);
    tick();
    flush = 1'b0; wb_valid = 1'b0; id_valid = 0; #1;
    chk("flush_busy", 32'(busy_mask), 32'h0);
    chk("flush_inflight", 32'(inflight), 0);
    chk("flush_iss_valid", 32'(iss_valid), 0);
    wb(1);
    chk("late_wb_busy", 32'(busy_mask), 32'h0);
    chk("late_wb_inflight", 32'(inflight), 0);
    wb(0);
    chk("wb_x0_inflight", 32'(inflight), 0);

    // Asynchronous reset mid-operation
    present(7, 0, 0, 1, 0); tick();
    id_valid = 0;
    chk("pre_areset_busy", 32'(busy_mask), 32'h80);
    #2 reset = 1'b1; #1;
    chk("areset_busy", 32'(busy_mask), 32'h0);
    chk("areset_inflight", 32'(inflight), 0);
    chk("areset_iss_valid", 32'(iss_valid), 0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-hazard scoreboard and issue controller between the instruction decoder and the execute stage. Takes decoded register indices from the decoder, tracks destination registers with outstanding writebacks, stalls decode on RAW/WAW hazards or when the in-flight limit is reached, and registers issued instructions into a one-entry output stage under valid/ready flow control. Writeback clears the busy bits.

## Interface
- NUM_REGS, 32: architectural registers. Index 0 is hard-wired zero.
- MAX_INFLIGHT, 4: maximum outstanding register writes. Range 1..31.
- CW, $clog2(MAX_INFLIGHT+1): in-flight counter width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  scoreboard accepts instruction this cycle.
- id_rd, id_rs1, id_rs2  in  5 each  decoded register indices.
- id_writes_rd  in  1  instruction writes id_rd.
- id_uses_rs2  in  1  instruction reads id_rs2.
- iss_valid  out  1  issued instruction held in the output stage.
- iss_ready  in  1  execute accepts the output stage.
- iss_rd, iss_rs1, iss_rs2  out  5 each  registered indices of the issued instruction.
- iss_writes_rd  out  1  registered copy of id_writes_rd, masked to 0 when rd==0.
- wb_valid  in  1  register writeback completes.
- wb_rd  in  5  writeback destination.
- flush  in  1  pipeline kill.
- busy_mask  out  NUM_REGS  scoreboard state. Bit 0 is always 0.
- inflight  out  CW  outstanding write count.

## Operation
- The hazard check is combinational on the registered busy_mask. There is no writeback bypass: a register cleared by wb in cycle N is usable by id in cycle N+1.
- raw: (rs1!=0 && busy[rs1]) || (id_uses_rs2 && rs2!=0 && busy[rs2]).
- waw: id_writes_rd && rd!=0 && busy[rd].
- full: id_writes_rd && rd!=0 && inflight==MAX_INFLIGHT.
- stage_free: !iss_valid || iss_ready.
- id_ready = !flush && !raw && !waw && !full && stage_free. The value is independent of id_valid.
- id_fire = id_valid && id_ready.
- On id_fire:
  - The output stage loads the id fields.
  - iss_valid is set to 1.
  - If writes_rd and rd!=0: busy[rd] is set and inflight increments.
- If iss_valid && iss_ready && !id_fire: iss_valid is set to 0.
- On wb_valid with wb_rd!=0 and busy[wb_rd]==1: the busy bit is cleared and inflight decrements.
  - A writeback to a non-busy register or to x0 is ignored: no state change, no count change.
- Same-cycle set and clear:
  - Set and clear cannot target the same register, because WAW blocks that case.
  - inflight is updated by (+1 set) + (−1 clear). Net 0 when both occur.
- flush has priority over everything:
  - Next cycle: busy_mask=0, inflight=0, iss_valid=0.
  - id_ready=0 during the flush cycle.
  - A writeback arriving in the same cycle as flush is discarded.
  - Late writebacks of flushed operations are suppressed upstream.
- Invariant: inflight == popcount(busy_mask). This is checked by assertion.

## Timing
- Reset values: busy_mask=0, inflight=0, iss_valid=0, iss_rd/rs1/rs2=0, iss_writes_rd=0. id_ready therefore evaluates to 1 after reset when no flush is asserted.
- Issue latency: 1 cycle from id_fire to iss_valid.
- Throughput: 1 instruction per cycle with no hazards and iss_ready held high.
- Backpressure:
  - While iss_valid && !iss_ready, the output stage holds all iss_* stable and id_ready=0.
  - When iss_ready=1 and a new instruction fires in the same cycle, the stage is replaced back-to-back with no bubble.
- Scoreboard updates (set, clear, flush) are visible to the hazard check the following cycle.
- If reset asserts mid-operation, all state clears immediately. In-flight writebacks arriving after reset is released are ignored per the non-busy rule.

## Structure
- The shared package holds:
  - REG_IDX_W=5.
  - The reg_idx_t typedef.
  - A struct for the issue fields {rd, rs1, rs2, writes_rd}. The decoder and execute stage share this struct.
- One sub-module, hazard_check: purely combinational, takes busy_mask and the id fields, produces raw, waw and full.
- The busy register, counter and output stage stay in the top module.

## Test plan
- Post-reset issue: issue add x3,x1,x2 with writes_rd=1 → iss_valid=1 next cycle, busy_mask=0x8, inflight=1.
- RAW stall: x5 busy; present rs1=5 → id_ready=0. Assert wb_rd=5 in cycle N → id_ready=1 in N+1, not N.
- WAW and x0: rd=5 while x5 is busy → stall. rd=0 with writes_rd=1 → no busy bit set, inflight unchanged, iss_writes_rd=0.
- Full limit (MAX_INFLIGHT=4): issue writes to x1..x4 → inflight=4. A write to x6 stalls. A store (writes_rd=0, rs1=7) issues. wb x2 → x6 issues the next cycle.
- Backpressure: hold iss_ready=0 for 3 cycles with id_valid=1 → iss_* stable, id_ready=0. Release → back-to-back issue with no bubble.
- Flush and edge writebacks: with x1 and x9 busy, assert flush with wb_rd=9 → next cycle busy_mask=0, inflight=0, iss_valid=0. A later wb_rd=1 causes no change and no underflow.
